// File: rtl/opacc_seq_if.sv
// Command, data-stream, store-stream and accumulator-strobe bundle for opacc_seq.
interface opacc_seq_if #(
    parameter int unsigned AW = 1,
    parameter int unsigned DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_k;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] in_c;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    logic          ab_valid;
    logic [AW-1:0] ab_addr;
    logic [DW-1:0] ai;
    logic [DW-1:0] bi;
    logic          c_valid;
    logic [AW-1:0] ci_addr;
    logic [DW-1:0] ci;
    logic [DW-1:0] co;

    logic          busy;
    logic          done;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_k,
        input  in_valid, in_a, in_b, in_c,
        input  out_ready, co,
        output cmd_ready, in_ready, out_valid, out_data,
        output ab_valid, ab_addr, ai, bi, c_valid, ci_addr, ci,
        output busy, done
    );

    // Command/stream source and accumulator side
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_k,
        output in_valid, in_a, in_b, in_c,
        output out_ready, co,
        input  cmd_ready, in_ready, out_valid, out_data,
        input  ab_valid, ab_addr, ai, bi, c_valid, ci_addr, ci,
        input  busy, done
    );
endinterface

// File: rtl/opacc_seq.sv
// Outer-product accumulator sequencer: turns LOAD/MAC/STORE/ZERO commands
// into combinational strobes toward a row-shifting accumulator tile array.
module opacc_seq #(
    parameter int unsigned NUM_MREGS = 2,
    parameter int unsigned XLEN      = 8,
    parameter int unsigned VLEN      = 32,
    parameter int unsigned MLEN      = 32,
    parameter int unsigned AW        = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1
) (
    input  logic        clk,
    input  logic        reset,
    opacc_seq_if.slave  bus
);
    localparam int unsigned ML = MLEN / XLEN;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0]   ML_CNT   = CW'(ML);
    localparam logic [VLEN-1:0] ZERO_ROW = '0;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_MAC   = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_ZERO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        STORE = 3'd3,
        ZERO  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          done_q, done_d;
    logic          beat_c;

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.ab_addr   = addr_q;
    assign bus.ci_addr   = addr_q;

    // State, beat counter, latched tile address and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Next state and combinational strobe passthrough
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        done_d       = 1'b0;
        beat_c       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = ZERO_ROW;
        bus.ab_valid  = 1'b0;
        bus.ai        = ZERO_ROW;
        bus.bi        = ZERO_ROW;
        bus.c_valid   = 1'b0;
        bus.ci        = ZERO_ROW;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            state_d = LOAD;
                            cnt_d   = ML_CNT;
                        end
                        OP_MAC: begin
                            // An empty MAC completes without leaving IDLE
                            if (bus.cmd_k == '0) begin
                                cnt_d  = '0;
                                done_d = 1'b1;
                            end else begin
                                state_d = MAC;
                                cnt_d   = bus.cmd_k;
                            end
                        end
                        OP_STORE: begin
                            state_d = STORE;
                            cnt_d   = ML_CNT;
                        end
                        default: begin
                            state_d = ZERO;
                            cnt_d   = ML_CNT;
                        end
                    endcase
                end
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                bus.c_valid  = bus.in_valid;
                bus.ci       = bus.in_c;
                beat_c       = bus.in_valid;
            end
            MAC: begin
                bus.in_ready = 1'b1;
                bus.ab_valid = bus.in_valid;
                bus.ai       = bus.in_a;
                bus.bi       = bus.in_b;
                beat_c       = bus.in_valid;
            end
            STORE: begin
                // Reading a row shifts a zero row in behind it
                bus.out_valid = 1'b1;
                bus.out_data  = bus.co;
                bus.c_valid   = bus.out_ready;
                beat_c        = bus.out_ready;
            end
            ZERO: begin
                bus.c_valid = 1'b1;
                beat_c      = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (beat_c) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_opacc_seq.sv
// Directed self-checking bench for opacc_seq (ml=4, vl=4, XLEN=8).
module tb_opacc_seq;
    localparam int unsigned AW = 1;
    localparam int unsigned DW = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    opacc_seq_if #(.AW(AW), .DW(DW)) bus ();

    opacc_seq #(
        .NUM_MREGS(2), .XLEN(8), .VLEN(32), .MLEN(32), .AW(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command on a falling edge; it is accepted at the next rising edge
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] k);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_k     = k;
        #1;
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] row;
        logic        pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        checks = 0;
        errors = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = '0;
        bus.cmd_k     = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;
        bus.co        = '0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_c_valid",   32'(bus.c_valid),   32'd0);
        chk("rst_ab_valid",  32'(bus.ab_valid),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_ci_addr",   32'(bus.ci_addr),   32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);

        // LOAD tile 0 with row i element j = i*j, stalling once before row 2
        issue(2'd0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                bus.in_valid  = 1'b0;
                #1;
                chk("load_stall_cvalid", 32'(bus.c_valid),  32'd0);
                chk("load_stall_busy",   32'(bus.busy),     32'd1);
                chk("load_stall_inrdy",  32'(bus.in_ready), 32'd1);
            end
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            row = {8'(i * 3), 8'(i * 2), 8'(i), 8'h00};
            bus.in_valid = 1'b1;
            bus.in_c     = row;
            #1;
            chk("load_cvalid",   32'(bus.c_valid),   32'd1);
            chk("load_ci",       bus.ci,             row);
            chk("load_ci_addr",  32'(bus.ci_addr),   32'd0);
            chk("load_cmd_rdy",  32'(bus.cmd_ready), 32'd0);
            chk("load_abvalid",  32'(bus.ab_valid),  32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("load_done",      32'(bus.done),      32'd1);
        chk("load_idle_busy", 32'(bus.busy),      32'd0);
        chk("load_cmd_rdy2",  32'(bus.cmd_ready), 32'd1);
        chk("load_post_cv",   32'(bus.c_valid),   32'd0);
        @(negedge clk);
        #1;
        chk("load_done_once", 32'(bus.done), 32'd0);

        // MAC tile 1, k=3
        issue(2'd1, 1'b1, 8'd3);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_a      = 32'h0A07_0401;
            bus.in_b      = 32'h0B08_0502;
            #1;
            chk("mac_abvalid", 32'(bus.ab_valid), 32'd1);
            chk("mac_ab_addr", 32'(bus.ab_addr),  32'd1);
            chk("mac_ai",      bus.ai,            32'h0A07_0401);
            chk("mac_bi",      bus.bi,            32'h0B08_0502);
            chk("mac_cvalid",  32'(bus.c_valid),  32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("mac_done",       32'(bus.done),     32'd1);
        chk("mac_post_abv",   32'(bus.ab_valid), 32'd0);
        chk("mac_post_ai",    bus.ai,            32'd0);
        chk("mac_addr_idle",  32'(bus.ab_addr),  32'd1);
        @(negedge clk);
        #1;
        chk("mac_done_once",  32'(bus.done),     32'd0);

        // STORE tile 1 with out_ready 1,0,1,1,0,1
        issue(2'd2, 1'b1, 8'd0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.out_ready = pat[n];
            bus.co        = 32'hC0DE_0000 + 32'(n);
            #1;
            chk("st_out_valid", 32'(bus.out_valid), 32'd1);
            chk("st_out_data",  bus.out_data,       32'hC0DE_0000 + 32'(n));
            chk("st_cvalid",    32'(bus.c_valid),   32'(pat[n]));
            chk("st_ci",        bus.ci,             32'd0);
            chk("st_ci_addr",   32'(bus.ci_addr),   32'd1);
            chk("st_done_mid",  32'(bus.done),      32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("st_done",      32'(bus.done),      32'd1);
        chk("st_post_ov",   32'(bus.out_valid), 32'd0);
        chk("st_post_data", bus.out_data,       32'd0);

        // MAC with k=0 completes from IDLE
        issue(2'd1, 1'b0, 8'd0);
        chk("k0_busy_acc", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        chk("k0_done",    32'(bus.done),      32'd1);
        chk("k0_busy",    32'(bus.busy),      32'd0);
        chk("k0_abvalid", 32'(bus.ab_valid),  32'd0);
        chk("k0_cmd_rdy", 32'(bus.cmd_ready), 32'd1);
        chk("k0_addr",    32'(bus.ci_addr),   32'd0);
        @(negedge clk);
        #1;
        chk("k0_done_once", 32'(bus.done), 32'd0);

        // LOAD tile 1 abandoned by reset after two beats
        issue(2'd0, 1'b1, 8'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_c      = 32'h1111_1111 * 32'(i + 1);
            #1;
            chk("abort_cvalid", 32'(bus.c_valid), 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy",    32'(bus.busy),      32'd0);
        chk("abort_cmd_rdy", 32'(bus.cmd_ready), 32'd1);
        chk("abort_cvalid0", 32'(bus.c_valid),   32'd0);
        chk("abort_done",    32'(bus.done),      32'd0);
        chk("abort_addr",    32'(bus.ci_addr),   32'd0);
        @(negedge clk);
        #1;
        chk("abort_done2",   32'(bus.done),      32'd0);

        // ZERO tile 0, with garbage on in_c that must not leak
        issue(2'd3, 1'b0, 8'd0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_c      = 32'hFFFF_FFFF;
            #1;
            chk("zero_cvalid", 32'(bus.c_valid),  32'd1);
            chk("zero_ci",     bus.ci,            32'd0);
            chk("zero_inrdy",  32'(bus.in_ready), 32'd0);
            chk("zero_done0",  32'(bus.done),     32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("zero_done",    32'(bus.done),    32'd1);
        chk("zero_post_cv", 32'(bus.c_valid), 32'd0);
        chk("zero_busy",    32'(bus.busy),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
